// File: rtl/jk_seq_pkg.sv
// Shared definitions for the JK count sequencer: state encoding and default width.
package jk_seq_pkg;

  localparam int WIDTH_DEF = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2,
    ST_DONE = 2'd3
  } seq_state_e;

endpackage

// File: rtl/jk_cell.sv
// Single JK flip-flop with asynchronous clear. Q_not is the complement of Q.
module jk_cell (
  input  logic J,
  input  logic K,
  input  logic clk,
  input  logic reset,
  output logic Q,
  output logic Q_not
);

  // JK truth table: hold / clear / set / toggle
  always_ff @(posedge clk or posedge reset) begin
    if (reset) Q <= 1'b0;
    else begin
      case ({J, K})
        2'b00:   Q <= Q;
        2'b01:   Q <= 1'b0;
        2'b10:   Q <= 1'b1;
        default: Q <= ~Q;
      endcase
    end
  end

  assign Q_not = ~Q;

endmodule

// File: rtl/jk_count_sequencer.sv
// Run-controlled modulo up/down counter built from a bank of JK cells.
// The FSM state is the only storage here; the count lives in the JK bank and
// is steered purely through combinational J/K decode.
module jk_count_sequencer
  import jk_seq_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             stop,
  input  logic             up_dn,
  input  logic             load_en,
  input  logic [WIDTH-1:0] load_val,
  input  logic [WIDTH-1:0] mod_max,
  output logic [WIDTH-1:0] cnt,
  output logic             busy,
  output logic             tc,
  output logic             done
);

  seq_state_e       state;
  logic [WIDTH-1:0] j_vec, k_vec;
  logic [WIDTH-1:0] q_not;
  logic [WIDTH-1:0] inc_tgl, dec_tgl;
  logic [WIDTH-1:0] preload;
  logic             at_max, at_zero, wrap;

  // JK bank: one cell per count bit
  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_bank
      jk_cell u_cell (
        .J     (j_vec[gi]),
        .K     (k_vec[gi]),
        .clk   (clk),
        .reset (reset),
        .Q     (cnt[gi]),
        .Q_not (q_not[gi])
      );
    end
  endgenerate

  assign at_max  = (cnt == mod_max);
  assign at_zero = (cnt == '0);
  assign wrap    = up_dn ? at_max : at_zero;
  // Out-of-range preload values start the run from zero instead.
  assign preload = (load_val > mod_max) ? '0 : load_val;

  // Ripple-style toggle masks: up toggles above a run of 1s, down above a run of 0s
  always_comb begin
    inc_tgl    = '0;
    dec_tgl    = '0;
    inc_tgl[0] = 1'b1;
    dec_tgl[0] = 1'b1;
    for (int i = 1; i < WIDTH; i++) begin
      inc_tgl[i] = inc_tgl[i-1] &  cnt[i-1];
      dec_tgl[i] = dec_tgl[i-1] & ~cnt[i-1];
    end
  end

  // J/K steering per state
  always_comb begin
    j_vec = '0;
    k_vec = '0;
    case (state)
      ST_LOAD: begin
        j_vec = preload;
        k_vec = ~preload;
      end
      ST_RUN: begin
        if (up_dn) begin
          if (at_max) begin
            j_vec = '0;
            k_vec = '1;
          end else begin
            j_vec = inc_tgl;
            k_vec = inc_tgl;
          end
        end else begin
          if (at_zero) begin
            j_vec = mod_max;
            k_vec = ~mod_max;
          end else begin
            j_vec = dec_tgl;
            k_vec = dec_tgl;
          end
        end
      end
      default: begin
        j_vec = '0;
        k_vec = '0;
      end
    endcase
  end

  // Run-control FSM; start only matters in IDLE, stop only in RUN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else begin
      case (state)
        ST_IDLE: if (start) state <= load_en ? ST_LOAD : ST_RUN;
        ST_LOAD: state <= ST_RUN;
        ST_RUN:  if (stop) state <= ST_DONE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Decoded status outputs, no extra register stage
  assign busy = (state == ST_LOAD) || (state == ST_RUN);
  assign done = (state == ST_DONE);
  assign tc   = (state == ST_RUN) && wrap;

endmodule

// File: tb/tb_jk_count_sequencer.sv
// Directed bench for jk_count_sequencer (WIDTH=4) with hand-computed expectations.
module tb_jk_count_sequencer;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         reset;
  logic         start, stop, up_dn, load_en;
  logic [W-1:0] load_val, mod_max;
  logic [W-1:0] cnt;
  logic         busy, tc, done;

  int checks = 0;
  int errors = 0;

  jk_count_sequencer #(.WIDTH(W)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .stop     (stop),
    .up_dn    (up_dn),
    .load_en  (load_en),
    .load_val (load_val),
    .mod_max  (mod_max),
    .cnt      (cnt),
    .busy     (busy),
    .tc       (tc),
    .done     (done)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input int e_cnt, input bit e_busy,
                         input bit e_tc, input bit e_done);
    chk({tag, ".cnt"},  32'(cnt),  32'(e_cnt));
    chk({tag, ".busy"}, 32'(busy), 32'(e_busy));
    chk({tag, ".tc"},   32'(tc),   32'(e_tc));
    chk({tag, ".done"}, 32'(done), 32'(e_done));
  endtask

  int exp_dn [6] = '{3, 2, 1, 0, 9, 8};

  initial begin
    reset = 1'b1; start = 0; stop = 0; up_dn = 1; load_en = 0;
    load_val = '0; mod_max = 4'd9;
    #1;
    chk_all("reset", 0, 0, 0, 0);
    @(negedge clk) reset = 1'b0;
    step();
    chk_all("idle_after_reset", 0, 0, 0, 0);

    // mod-10 up count, no preload
    start = 1;
    step();
    start = 0;
    for (int i = 0; i < 10; i++) begin
      chk_all($sformatf("up_mod10[%0d]", i), i, 1, (i == 9), 0);
      step();
    end
    chk_all("up_wrap", 0, 1, 0, 0);
    stop = 1;
    step();
    stop = 0;
    chk_all("up_stop_done", 1, 0, 0, 1);
    step();
    chk_all("up_idle", 1, 0, 0, 0);

    // preload 3 then count down through the wrap to mod_max
    load_en = 1; load_val = 4'd3; up_dn = 0; start = 1;
    step();
    start = 0;
    chk_all("load_cycle", 1, 1, 0, 0);
    step();
    for (int i = 0; i < 6; i++) begin
      chk_all($sformatf("down[%0d]", i), exp_dn[i], 1, (exp_dn[i] == 0), 0);
      if (i == 1) start = 1;
      if (i == 2) start = 0;
      if (i < 5) step();
    end
    stop = 1;
    step();
    stop = 0;
    chk_all("down_stop_done", 7, 0, 0, 1);
    step();
    chk_all("down_idle", 7, 0, 0, 0);

    // out-of-range preload gives zero; then stop at 4 going up
    load_val = 4'd12; up_dn = 1; start = 1;
    step();
    start = 0;
    chk_all("load12_cycle", 7, 1, 0, 0);
    step();
    chk_all("load12_run", 0, 1, 0, 0);
    repeat (4) step();
    chk_all("run_at4", 4, 1, 0, 0);
    stop = 1;
    step();
    stop = 0; start = 1;
    chk_all("stop_at4_done", 5, 0, 0, 1);
    step();
    start = 0;
    chk_all("after_done_idle", 5, 0, 0, 0);
    step();
    chk_all("idle_hold5", 5, 0, 0, 0);

    // mod_max=0: stuck at zero, tc every RUN cycle, start pulses ignored
    mod_max = 4'd0; load_val = 4'd3; start = 1;
    step();
    start = 0;
    step();
    for (int i = 0; i < 4; i++) begin
      chk_all($sformatf("mod0[%0d]", i), 0, 1, 1, 0);
      if (i == 1) start = 1;
      if (i == 2) begin start = 0; up_dn = 0; end
      step();
    end
    stop = 1;
    step();
    stop = 0;
    chk_all("mod0_done", 0, 0, 0, 1);
    step();

    // direction change mid-run takes effect on the next edge
    mod_max = 4'd9; load_val = 4'd5; up_dn = 1; start = 1;
    step();
    start = 0;
    step();
    chk_all("dir_load5", 5, 1, 0, 0);
    step();
    chk_all("dir_up6", 6, 1, 0, 0);
    up_dn = 0;
    step();
    chk_all("dir_dn5", 5, 1, 0, 0);
    step();
    chk_all("dir_dn4", 4, 1, 0, 0);
    up_dn = 1;
    step();
    chk_all("pre_reset5", 5, 1, 0, 0);

    // asynchronous reset mid-RUN aborts without done
    #2 reset = 1'b1;
    #1;
    chk_all("async_reset", 0, 0, 0, 0);
    load_en = 0; start = 1;
    @(negedge clk) reset = 1'b0;
    step();
    start = 0;
    chk_all("first_edge_start", 0, 1, 0, 0);
    stop = 1;
    step();
    stop = 0;
    chk_all("final_done", 1, 0, 0, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
